// File: rtl/lcd_video_pkg.sv
// Shared definitions for the LCD video output path: stream-lock states,
// default 800x480 panel timing and the colour-bar palette used by the
// optional test pattern (LCD_TEST_PATTERN_EN).
package lcd_video_pkg;

  // Default panel timing (800x480)
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 32;

  // Stream lock state: searching for SOP, holding SOP for frame start, locked
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } stream_state_t;

  // Colour-bar palette, left to right across the active line
  localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFF_FF_00;
  localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
  localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
  localparam logic [23:0] BAR_BLUE    = 24'h00_00_FF;
  localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

  function automatic logic [23:0] colour_bar(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced on pix_ce,
// with combinational active/sync/frame-position flags for the parent FSM.
module lcd_timing_gen
  import lcd_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  localparam int VW = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  output logic [HW-1:0] h_count,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          last_pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [31:0]   h32;
  logic [31:0]   v32;

  // Advance the raster one pixel per pix_ce, wrapping line then frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  // Compare in 32 bits so sync windows ending exactly at the total never overflow
  assign h32 = 32'(h_q);
  assign v32 = 32'(v_q);

  assign h_count     = h_q;
  assign active      = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign hsync       = (h32 >= H_ACTIVE + H_FRONT) && (h32 < H_ACTIVE + H_FRONT + H_SYNC);
  assign vsync       = (v32 >= V_ACTIVE + V_FRONT) && (v32 < V_ACTIVE + V_FRONT + V_SYNC);
  assign frame_start = (h32 == 0) && (v32 == 0);
  assign last_pixel  = (h32 == H_ACTIVE - 1) && (v32 == V_ACTIVE - 1);

endmodule

// File: rtl/lcd_stream_to_video_out.sv
// Terminal stage of the LCD path: locks an Avalon-ST pixel stream (one packet
// per frame) to the raster, drives the parallel RGB panel pins and blanks or
// resynchronises on underflow and framing errors.
// Optional build macro LCD_TEST_PATTERN_EN adds a test_pattern input that
// replaces the stream with eight vertical colour bars.
module lcd_stream_to_video_out
  import lcd_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [1:0]  in_empty,
  output logic        lcd_hsync_n,
  output logic        lcd_vsync_n,
  output logic        lcd_de,
  output logic [7:0]  lcd_r,
  output logic [7:0]  lcd_g,
  output logic [7:0]  lcd_b,
  output logic        underflow,
  output logic        sync_err
);

  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);

  stream_state_t state_q, state_d;
  logic          run_q;
  logic [HW-1:0] h_count;
  logic          active, hsync, vsync, frame_start, last_pixel;
  logic [23:0]   pix_rgb;
  logic          underflow_d, sync_err_d;
  logic          tp_on;
  logic [23:0]   bar_rgb;
  logic          unused_bits;

  assign unused_bits = ^{in_data[31:24], in_empty};

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .h_count     (h_count),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .last_pixel  (last_pixel)
  );

`ifdef LCD_TEST_PATTERN_EN
  // Bars are at least one pixel wide so tiny test rasters stay well defined
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [31:0] bar_idx32;
  logic [2:0]  bar_idx;

  assign bar_idx32 = 32'(h_count) / BAR_W;
  assign bar_idx   = (bar_idx32 > 32'd7) ? 3'd7 : bar_idx32[2:0];
  assign bar_rgb   = colour_bar(bar_idx);
  assign tp_on     = test_pattern;
`else
  logic unused_h;

  assign unused_h = ^h_count;
  assign bar_rgb  = 24'h0;
  assign tp_on    = 1'b0;
`endif

  // Ready is held low for the first clock after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Sink ready: drain junk while hunting, take SOP only at frame start, then one beat per active pixel
  always_comb begin
    in_ready = 1'b0;
    if (run_q) begin
      if (tp_on) begin
        in_ready = in_valid;
      end else begin
        case (state_q)
          HUNT:    in_ready = in_valid && !in_startofpacket;
          WAIT:    in_ready = pix_ce && frame_start && in_startofpacket;
          RUN:     in_ready = pix_ce && active && !in_startofpacket;
          default: in_ready = 1'b0;
        endcase
      end
    end
  end

  // Lock state transitions, pixel colour selection and error pulse generation
  always_comb begin
    state_d     = state_q;
    pix_rgb     = 24'h0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    if (run_q) begin
      if (tp_on) begin
        state_d = HUNT;
        pix_rgb = active ? bar_rgb : 24'h0;
      end else begin
        case (state_q)
          HUNT: begin
            if (in_valid && in_startofpacket) state_d = WAIT;
          end
          WAIT: begin
            if (pix_ce && frame_start && in_valid && in_startofpacket) begin
              pix_rgb = in_data[23:0];
              state_d = RUN;
            end else if (in_valid && !in_startofpacket) begin
              state_d = HUNT;
            end
          end
          RUN: begin
            if (pix_ce && active) begin
              if (!in_valid) begin
                underflow_d = 1'b1;
                state_d     = HUNT;
              end else if (in_startofpacket) begin
                sync_err_d = 1'b1;
                state_d    = WAIT;
              end else begin
                pix_rgb = in_data[23:0];
                if (last_pixel) begin
                  if (in_endofpacket) begin
                    state_d = WAIT;
                  end else begin
                    sync_err_d = 1'b1;
                    state_d    = HUNT;
                  end
                end else if (in_endofpacket) begin
                  sync_err_d = 1'b1;
                  state_d    = HUNT;
                end
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // Panel pins registered together on pix_ce; error pulses last exactly one clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_de      <= 1'b0;
      lcd_r       <= 8'h0;
      lcd_g       <= 8'h0;
      lcd_b       <= 8'h0;
      underflow   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      underflow <= underflow_d;
      sync_err  <= sync_err_d;
      if (pix_ce) begin
        lcd_hsync_n <= !hsync;
        lcd_vsync_n <= !vsync;
        lcd_de      <= active;
        lcd_r       <= pix_rgb[23:16];
        lcd_g       <= pix_rgb[15:8];
        lcd_b       <= pix_rgb[7:0];
      end
    end
  end

endmodule

// File: doc/lcd_stream_to_video_out.md
Name: lcd_stream_to_video_out

Overview:
- Terminal stage of the LCD display path. Consumes the 32-bit Avalon-ST pixel stream produced by the LCD 64-to-32-bit format adapter.
- Drives the panel's parallel RGB interface (HSYNC/VSYNC/DE/RGB) from an internal raster timing generator.
- Each packet is one frame: SOP marks the first pixel, EOP marks the last.
- Locks packets to raster frame start, blanks on underflow and resynchronises on framing errors.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, HSYNC pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 13, vertical front porch (lines)
- V_SYNC, 3, VSYNC pulse width (lines)
- V_BACK, 32, vertical back porch (lines)

Ports:
- clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel clock enable; raster advances only when high
- in_ready  out  1  sink ready, readyLatency 0
- in_valid  in  1  source valid
- in_data  in  32  pixel: [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
- in_startofpacket  in  1  first pixel of frame
- in_endofpacket  in  1  last pixel of frame
- in_empty  in  2  ignored (always 0 for whole pixels)
- lcd_hsync_n  out  1  horizontal sync, active low
- lcd_vsync_n  out  1  vertical sync, active low
- lcd_de  out  1  data enable
- lcd_r / lcd_g / lcd_b  out  8 each  pixel colour
- underflow  out  1  one-cycle pulse: active pixel with no valid beat
- sync_err  out  1  one-cycle pulse: framing mismatch detected

Behaviour:
- Reset (asynchronous, active-low):
  - Counters go to h=0, v=0 and state goes to HUNT.
  - Outputs: hsync_n=1, vsync_n=1, de=0, rgb=0, underflow=0, sync_err=0.
  - in_ready=0 while reset_n is low and for the first clk after release (gated by a registered run flag).
- Raster counters:
  - h wraps at H_TOTAL-1 = sum of the H parameters; v increments on h wrap and wraps at V_TOTAL-1.
  - Both advance only on pix_ce.
  - active = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync asserted while h is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). vsync uses the same rule with the V parameters, evaluated on v.
- Output timing:
  - All panel outputs are registered and update only on pix_ce.
  - Latency is 1 clk from the counter/beat-accept cycle to the pins. hsync, vsync, de and rgb are always mutually aligned.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready is combinational from state, counters, pix_ce and in_startofpacket. in_ready never depends on in_ready.
- State HUNT:
  - in_ready = in_valid && !in_startofpacket; non-SOP beats are discarded at 1 per clk regardless of pix_ce.
  - A valid SOP beat is held (in_ready=0) and the state moves to WAIT.
- State WAIT:
  - in_ready=0 except at the frame-start pixel (h=0, v=0, pix_ce=1). There the SOP beat is accepted and output, and the state moves to RUN.
- State RUN: in_ready = pix_ce && active.
  - Normal pixel: the beat is accepted and its RGB driven.
  - Underflow (active pixel, pix_ce, !in_valid): drive RGB=0 with DE=1, pulse underflow, go to HUNT. The rest of the frame is black.
  - SOP on a non-first pixel: not accepted; pulse sync_err, output black, go to WAIT.
  - EOP before the last active pixel (h=H_ACTIVE-1, v=V_ACTIVE-1): beat accepted and displayed; pulse sync_err, go to HUNT.
  - Last active pixel without EOP: beat displayed; pulse sync_err, go to HUNT.
  - Last pixel with EOP: go to WAIT (next SOP aligns to the next frame).
- Blanking in HUNT/WAIT:
  - In HUNT, and in WAIT outside frame start, active pixels drive DE=1 with RGB=0.
  - Sync timing is never interrupted by stream state.
- pix_ce=0 during RUN: no accept, outputs hold.
- Simultaneous events:
  - Underflow and sync_err cannot coincide in one cycle.
  - A SOP+EOP single-beat packet in RUN counts as mid-frame SOP.

Optional Feature:
- LCD_TEST_PATTERN_EN
- With macro:
  - Adds input test_pattern (1 bit).
  - When high: 8 vertical colour bars of width H_ACTIVE/8, order white, yellow, cyan, green, magenta, red, blue, black. The stream FSM is forced to HUNT and incoming beats are drained.
  - Deasserting test_pattern resumes normal locking.
- Without macro: port absent; behaviour as above.

Decomposition:
- Package lcd_video_pkg:
  - state enum {HUNT, WAIT, RUN}
  - default 800x480 timing constants
  - colour-bar RGB constants
- Sub-module lcd_timing_gen:
  - Contains the h/v counters, pix_ce gating, active, hsync, vsync and frame_start/last_pixel flags.
  - Combinational flag outputs are used by the parent's FSM.

Test Plan (bench uses H_ACTIVE=4, H_FRONT=1, H_SYNC=1, H_BACK=1, V_ACTIVE=2, V_FRONT=V_SYNC=V_BACK=1, pix_ce=1):
- Reset, no stream -> de pulses 4 clk per active line, rgb=0, hsync_n low 1 clk per 7-clk line, vsync_n low for 1 line of 5.
- 8-beat packet, data 0x01..0x08, always valid -> SOP accepted at h=0,v=0; rgb 0x000001..0x000008 on the next 8 DE cycles; in_ready low elsewhere.
- 3 junk beats then SOP mid-frame -> junk drained at 1/clk, SOP held until next frame start, then 8 pixels displayed.
- in_valid dropped at pixel 5 -> underflow pulses once, pixels 5..8 black, relock on next SOP.
- EOP on beat 6 -> sync_err pulse, pixels 7..8 black; next packet displays cleanly.
- pix_ce toggled 1/0 -> one accept per pix_ce high, outputs stable while pix_ce=0.
